// File: rtl/traffic_conflict_monitor.sv
// Lamp safety stage: passes legal lamp patterns, blanks to all-red or flashes red on illegal ones.
// Latency 1 cycle (registered lamps); no backpressure, outputs are always live.
module traffic_conflict_monitor #(
    parameter int CONFLICT_CYC = 2,
    parameter int RECOVER_CYC  = 16,
    parameter int FLASH_HALF   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m_red,
    input  logic       m_green,
    input  logic       m_yellow,
    input  logic       s_red,
    input  logic       s_green,
    input  logic       s_yellow,
    input  logic       fault_clr,
    output logic       lm_red,
    output logic       lm_green,
    output logic       lm_yellow,
    output logic       ls_red,
    output logic       ls_green,
    output logic       ls_yellow,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_PASS,
        ST_PENDING,
        ST_FAULT
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] bad_cnt, bad_cnt_nxt;
    logic [7:0] clean_cnt, clean_cnt_nxt;
    logic [7:0] flash_cnt, flash_cnt_nxt;
    logic       flash_on, flash_on_nxt;
    logic [2:0] code_nxt;
    logic [5:0] lamp_q, lamp_nxt;

    logic       conflict, multi, dark, bad;
    logic [2:0] cls;

    always_comb begin
        conflict = (m_green | m_yellow) & (s_green | s_yellow);
        multi    = (m_red & m_green) | (m_red & m_yellow) | (m_green & m_yellow)
                 | (s_red & s_green) | (s_red & s_yellow) | (s_green & s_yellow);
        dark     = ~(m_red | m_green | m_yellow) | ~(s_red | s_green | s_yellow);
        cls      = 3'd0;
        if (conflict)
            cls = 3'd1;
        else if (multi)
            cls = 3'd2;
        else if (dark)
            cls = 3'd3;
    end

    assign bad = (cls != 3'd0);

    always_comb begin
        state_nxt     = state;
        code_nxt      = fault_code;
        flash_cnt_nxt = flash_cnt;
        flash_on_nxt  = flash_on;

        if (!bad || state == ST_FAULT)
            bad_cnt_nxt = 4'd0;
        else if (bad_cnt != 4'(CONFLICT_CYC))
            bad_cnt_nxt = bad_cnt + 4'd1;
        else
            bad_cnt_nxt = bad_cnt;

        if (bad)
            clean_cnt_nxt = 8'd0;
        else if (clean_cnt != 8'(RECOVER_CYC))
            clean_cnt_nxt = clean_cnt + 8'd1;
        else
            clean_cnt_nxt = clean_cnt;

        // Fault latch outranks every other transition.
        if (state != ST_FAULT && bad && bad_cnt == 4'(CONFLICT_CYC - 1)) begin
            state_nxt     = ST_FAULT;
            code_nxt      = cls;
            flash_cnt_nxt = 8'd0;
            flash_on_nxt  = 1'b1;
        end else begin
            case (state)
                ST_PASS:    if (bad) state_nxt = ST_PENDING;
                ST_CLEAR: begin
                    if (bad)
                        state_nxt = ST_PENDING;
                    else if (clean_cnt == 8'(RECOVER_CYC - 1))
                        state_nxt = ST_PASS;
                end
                ST_PENDING: if (!bad) state_nxt = ST_CLEAR;
                default: begin
                    if (fault_clr && !bad && clean_cnt == 8'(RECOVER_CYC)) begin
                        state_nxt     = ST_CLEAR;
                        code_nxt      = 3'd0;
                        clean_cnt_nxt = 8'd0;
                    end else if (flash_cnt == 8'(FLASH_HALF - 1)) begin
                        flash_cnt_nxt = 8'd0;
                        flash_on_nxt  = ~flash_on;
                    end else begin
                        flash_cnt_nxt = flash_cnt + 8'd1;
                    end
                end
            endcase
        end

        // Lamps follow the next state so an illegal request never reaches them.
        case (state_nxt)
            ST_PASS:  lamp_nxt = {m_red, m_green, m_yellow, s_red, s_green, s_yellow};
            ST_FAULT: lamp_nxt = {flash_on_nxt, 2'b00, flash_on_nxt, 2'b00};
            default:  lamp_nxt = 6'b100100;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_CLEAR;
            bad_cnt    <= 4'd0;
            clean_cnt  <= 8'd0;
            flash_cnt  <= 8'd0;
            flash_on   <= 1'b0;
            lamp_q     <= 6'b100100;
            fault      <= 1'b0;
            fault_code <= 3'd0;
        end else begin
            state      <= state_nxt;
            bad_cnt    <= bad_cnt_nxt;
            clean_cnt  <= clean_cnt_nxt;
            flash_cnt  <= flash_cnt_nxt;
            flash_on   <= flash_on_nxt;
            lamp_q     <= lamp_nxt;
            fault      <= (state_nxt == ST_FAULT);
            fault_code <= code_nxt;
        end
    end

    assign {lm_red, lm_green, lm_yellow, ls_red, ls_green, ls_yellow} = lamp_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed scenarios plus random traffic,
// checked against a run-length based behavioural model.
module tb_traffic_conflict_monitor;

    localparam int CONF = 2;
    localparam int REC  = 16;
    localparam int FH   = 8;

    localparam int M_CLEAR   = 0;
    localparam int M_PASS    = 1;
    localparam int M_PENDING = 2;
    localparam int M_FAULT   = 3;

    localparam logic [9:0] ALL_RED = 10'b100100_0_000;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] req;
    logic       fault_clr;
    logic       m_red, m_green, m_yellow, s_red, s_green, s_yellow;
    logic       lm_red, lm_green, lm_yellow, ls_red, ls_green, ls_yellow;
    logic       fault;
    logic [2:0] fault_code;
    logic [9:0] obs;

    assign {m_red, m_green, m_yellow, s_red, s_green, s_yellow} = req;
    assign obs = {lm_red, lm_green, lm_yellow, ls_red, ls_green, ls_yellow, fault, fault_code};

    traffic_conflict_monitor #(
        .CONFLICT_CYC(CONF),
        .RECOVER_CYC (REC),
        .FLASH_HALF  (FH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_red     (m_red),
        .m_green   (m_green),
        .m_yellow  (m_yellow),
        .s_red     (s_red),
        .s_green   (s_green),
        .s_yellow  (s_yellow),
        .fault_clr (fault_clr),
        .lm_red    (lm_red),
        .lm_green  (lm_green),
        .lm_yellow (lm_yellow),
        .ls_red    (ls_red),
        .ls_green  (ls_green),
        .ls_yellow (ls_yellow),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: operating mode plus run lengths of consecutive bad/legal cycles
    int         md;
    int         bad_run;
    int         legal_run;
    int         t_fault;
    logic [2:0] code_m;
    logic [9:0] exp_v;

    function automatic logic [2:0] classify(input logic [5:0] r);
        int mn, sn;
        mn = int'(r[5]) + int'(r[4]) + int'(r[3]);
        sn = int'(r[2]) + int'(r[1]) + int'(r[0]);
        if ((r[4] | r[3]) && (r[1] | r[0])) return 3'd1;
        if (mn > 1 || sn > 1) return 3'd2;
        if (mn == 0 || sn == 0) return 3'd3;
        return 3'd0;
    endfunction

    task automatic compute_exp();
        logic on;
        case (md)
            M_PASS:  exp_v = {req, 1'b0, code_m};
            M_FAULT: begin
                on    = ((t_fault / FH) % 2) == 0;
                exp_v = {on, 2'b00, on, 2'b00, 1'b1, code_m};
            end
            default: exp_v = {6'b100100, 1'b0, code_m};
        endcase
    endtask

    task automatic model_reset();
        md = M_CLEAR; bad_run = 0; legal_run = 0; t_fault = 0; code_m = 3'd0;
        compute_exp();
    endtask

    task automatic model_step();
        logic [2:0] c;
        logic       b;
        logic       cleared;
        c = classify(req);
        b = (c != 3'd0);
        cleared = 1'b0;
        if (md != M_FAULT && b && bad_run + 1 >= CONF) begin
            md = M_FAULT; code_m = c; t_fault = 0; bad_run = 0; legal_run = 0;
        end else begin
            case (md)
                M_PASS:    if (b) md = M_PENDING;
                M_CLEAR: begin
                    if (b) md = M_PENDING;
                    else if (legal_run + 1 >= REC) md = M_PASS;
                end
                M_PENDING: if (!b) md = M_CLEAR;
                default: begin
                    if (fault_clr && !b && legal_run >= REC) begin
                        md = M_CLEAR; code_m = 3'd0; cleared = 1'b1;
                    end else begin
                        t_fault++;
                    end
                end
            endcase
            bad_run   = (b && md != M_FAULT) ? bad_run + 1 : 0;
            legal_run = (cleared || b) ? 0 : legal_run + 1;
        end
        compute_exp();
    endtask

    task automatic cycle(input logic [5:0] r, input logic clr);
        req = r;
        fault_clr = clr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rand_pat(input logic want_bad);
        logic [5:0] p;
        p = 6'(($urandom_range(0, 63)));
        while ((classify(p) != 3'd0) != want_bad)
            p = 6'(($urandom_range(0, 63)));
        return p;
    endfunction

    task automatic test_reset();
        rst = 1'b0; req = 6'b010100; fault_clr = 1'b0;
        #12;
        model_reset();
        vectors++;
        if (obs !== ALL_RED || obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset: got %b want %b", obs, ALL_RED);
        end
        #10 rst = 1'b1;
    endtask

    task automatic test_pass();
        logic [5:0] pats [4];
        pats = '{6'b001100, 6'b100010, 6'b100001, 6'b100100};
        for (int i = 0; i < 18; i++) begin
            cycle(6'b010100, 1'b0);
            vectors++;
            if (obs !== exp_v || (i == 14 && lm_green !== 1'b0) || (i == 15 && lm_green !== 1'b1)) begin
                miscompares++;
                $display("FAIL pass_entry cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(pats[i % 4], 1'b0);
            vectors++;
            if (obs !== {pats[i % 4], 4'b0000} || obs !== exp_v) begin
                miscompares++;
                $display("FAIL pass_follow cyc %0d: got %b want %b", i, obs, {pats[i % 4], 4'b0000});
            end
        end
    endtask

    task automatic test_glitch();
        cycle(6'b010010, 1'b0);
        vectors++;
        if (obs !== ALL_RED || obs !== exp_v) begin
            miscompares++;
            $display("FAIL glitch_blank: got %b want %b", obs, ALL_RED);
        end
        for (int j = 0; j < 18; j++) begin
            cycle(6'b010100, 1'b0);
            vectors++;
            if (obs !== exp_v || (j == 14 && obs !== ALL_RED) || (j == 15 && obs !== 10'b010100_0_000)) begin
                miscompares++;
                $display("FAIL glitch_recover cyc %0d: got %b want %b", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_fault_flash();
        cycle(6'b101001, 1'b0);
        cycle(6'b101001, 1'b0);
        vectors++;
        if (obs !== 10'b100100_1_001 || obs !== exp_v) begin
            miscompares++;
            $display("FAIL fault_entry: got %b want %b", obs, 10'b100100_1_001);
        end
        for (int k = 1; k < 34; k++) begin
            cycle(6'b101001, (k % 5) == 0);
            vectors++;
            if (obs !== exp_v || lm_red !== (((k / FH) % 2) == 0)) begin
                miscompares++;
                $display("FAIL fault_flash t=%0d: got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_fault_clear();
        for (int i = 0; i < 17; i++) begin
            cycle(6'b010100, i == 10 || i == 16);
            vectors++;
            if (obs !== exp_v || (i == 10 && fault !== 1'b1) || (i == 16 && obs !== ALL_RED)) begin
                miscompares++;
                $display("FAIL fault_clear cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
        for (int i = 0; i < 17; i++) begin
            cycle(6'b010100, 1'b0);
            vectors++;
            if (obs !== exp_v || (i == 14 && obs !== ALL_RED) || (i == 15 && obs !== 10'b010100_0_000)) begin
                miscompares++;
                $display("FAIL post_clear cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_codes();
        logic [5:0] bad_pats [2];
        logic [2:0] want [2];
        bad_pats = '{6'b000000, 6'b110100};
        want     = '{3'd3, 3'd2};
        for (int p = 0; p < 2; p++) begin
            cycle(bad_pats[p], 1'b0);
            cycle(bad_pats[p], 1'b0);
            vectors++;
            if (fault_code !== want[p] || fault !== 1'b1 || obs !== exp_v) begin
                miscompares++;
                $display("FAIL code_%0d: got %b want code %0d model %b", want[p], obs, want[p], exp_v);
            end
            for (int i = 0; i < 36; i++) begin
                cycle(6'b100010, 1'b1);
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL code_recover cyc %0d: got %b want %b", i, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(6'b010010, 1'b0);
        cycle(6'b010010, 1'b0);
        cycle(6'b010010, 1'b0);
        #3 rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs !== ALL_RED || obs !== exp_v) begin
            miscompares++;
            $display("FAIL async_reset: got %b want %b", obs, ALL_RED);
        end
        @(posedge clk);
        #4 rst = 1'b1;
        for (int i = 0; i < 18; i++) begin
            cycle(6'b010100, 1'b0);
            vectors++;
            if (obs !== exp_v || (i == 14 && obs !== ALL_RED) || (i == 15 && obs !== 10'b010100_0_000)) begin
                miscompares++;
                $display("FAIL reset_recover cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        int         n;
        logic [5:0] p;
        n = 0;
        while (n < 3000) begin
            int kind, len;
            kind = $urandom_range(0, 9);
            len  = (kind < 7) ? $urandom_range(1, 24) : $urandom_range(1, 3);
            p    = rand_pat(kind >= 7);
            for (int i = 0; i < len; i++) begin
                cycle(p, $urandom_range(0, 5) == 0);
                n++;
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL random cyc %0d req %b: got %b want %b", n, p, obs, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_glitch();
        test_fault_flash();
        test_fault_clear();
        test_codes();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
